// File: rtl/libcache.sv
// Shared cache-memory types: clock bundle, ECC-protected 128-bit word layout,
// scrub controller state encoding and its default background interval.
package libcache;

  localparam int CACHE_WORD_BITS        = 128;
  localparam int CACHE_ECC_BITS         = 18;
  localparam int SCRUB_INTERVAL_DEFAULT = 1024;

  typedef struct packed {
    logic clk;
    logic clk2x;
  } iu_clk_type;

  typedef struct packed {
    logic [CACHE_WORD_BITS-1:0] D;
    logic [CACHE_WORD_BITS-1:0] I;
  } cache_word_type;

  typedef struct packed {
    logic sberr;
    logic dberr;
  } ecc_error_type;

  typedef struct packed {
    cache_word_type            data;
    logic [CACHE_ECC_BITS-1:0] ecc_parity;
    ecc_error_type             ecc_error;
  } cache_data_type;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    CHECK,
    SCRUB_WR
  } scrub_state_type;

  // The memory computes ECC on write, so parity and flags leave here as zero.
  function automatic cache_data_type make_wr_word(input logic [CACHE_WORD_BITS-1:0] d);
    cache_data_type w;
    w            = '0;
    w.data.D     = d;
    w.data.I     = d;
    return w;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/bram_scrub_ctrl_128.sv
// Single-port BRAM front end for 128-bit ECC words: client reads/writes,
// write-back of corrected single-bit errors, and a background scrub sweep.
module bram_scrub_ctrl_128
  import libcache::*;
#(
  parameter int ADDRMSB        = 8,
  parameter int SCRUB_INTERVAL = SCRUB_INTERVAL_DEFAULT,
  parameter int RDLAT          = 2
) (
  input  iu_clk_type           gclk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDRMSB:0]     req_addr,
  input  logic [127:0]         req_data,
  output logic                 rsp_valid,
  output logic [127:0]         rsp_data,
  output logic                 rsp_dberr,
  output logic [ADDRMSB:0]     mem_addr,
  output logic                 mem_we,
  output cache_data_type       mem_din,
  input  cache_data_type       mem_dout,
  input  logic                 scrub_en,
  output logic [15:0]          sb_cnt,
  output logic [15:0]          db_cnt,
  output logic [ADDRMSB:0]     db_addr
);

  localparam int AW = ADDRMSB + 1;
  localparam int TW = $clog2(SCRUB_INTERVAL + 1);
  localparam int LW = (RDLAT > 1) ? $clog2(RDLAT) : 1;

  logic clk;
  assign clk = gclk.clk2x;

  logic unused_ok;
  assign unused_ok = ^{gclk.clk, mem_dout.data.I, mem_dout.ecc_parity};

  scrub_state_type state, state_nx;

  logic [LW-1:0]      wait_cnt;
  logic [TW-1:0]      timer;
  logic [ADDRMSB:0]   scrub_ptr;
  logic               is_scrub;
  logic               accept;
  logic               scrub_go;
  logic               scrub_due;
  logic               sberr_only;

  assign scrub_due  = scrub_en && (timer == TW'(SCRUB_INTERVAL));
  assign sberr_only = mem_dout.ecc_error.sberr && !mem_dout.ecc_error.dberr;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    accept    = 1'b0;
    scrub_go  = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (!req_we) state_nx = RD_WAIT;
        end else if (scrub_due) begin
          scrub_go = 1'b1;
          state_nx = RD_WAIT;
        end
      end
      RD_WAIT:  if (wait_cnt == LW'(RDLAT - 1)) state_nx = CHECK;
      CHECK:    state_nx = sberr_only ? SCRUB_WR : IDLE;
      // First cycle raises mem_we, second cycle is the write itself.
      SCRUB_WR: if (mem_we) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_dberr <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_din   <= '0;
      sb_cnt    <= '0;
      db_cnt    <= '0;
      db_addr   <= '0;
      wait_cnt  <= '0;
      scrub_ptr <= '0;
      is_scrub  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_dberr <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            mem_addr <= req_addr;
            mem_we   <= req_we;
            is_scrub <= 1'b0;
            wait_cnt <= '0;
            if (req_we) mem_din <= make_wr_word(req_data);
          end else if (scrub_go) begin
            mem_addr  <= scrub_ptr;
            mem_we    <= 1'b0;
            is_scrub  <= 1'b1;
            wait_cnt  <= '0;
            scrub_ptr <= scrub_ptr + AW'(1);
          end else begin
            mem_we <= 1'b0;
          end
        end
        RD_WAIT: wait_cnt <= wait_cnt + LW'(1);
        CHECK: begin
          // Scrub reads update the error bookkeeping but never respond.
          if (!is_scrub) begin
            rsp_valid <= 1'b1;
            rsp_data  <= mem_dout.data.D;
            rsp_dberr <= mem_dout.ecc_error.dberr;
          end
          if (mem_dout.ecc_error.dberr) begin
            db_cnt  <= sat_inc16(db_cnt);
            db_addr <= mem_addr;
          end else if (mem_dout.ecc_error.sberr) begin
            sb_cnt  <= sat_inc16(sb_cnt);
            mem_din <= make_wr_word(mem_dout.data.D);
          end
        end
        SCRUB_WR: mem_we <= ~mem_we;
        default:  mem_we <= 1'b0;
      endcase
    end
  end

  // The timer only advances in IDLE and parks at the interval until a scrub issues.
  always_ff @(posedge clk) begin
    if (rst || !scrub_en || scrub_go)
      timer <= '0;
    else if (state == IDLE && timer != TW'(SCRUB_INTERVAL))
      timer <= timer + TW'(1);
  end

endmodule
